// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: access-length encoding and FSM states.
// Imported by the controller top and its fetch buffer.
package cpu_defs;

  typedef enum logic [1:0] {
    LEN_BYTE = 2'd0,
    LEN_HALF = 2'd1,
    LEN_WORD = 2'd2,
    LEN_ILL  = 2'd3
  } mem_len_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_IF_READ   = 3'd1,
    ST_MEM_READ  = 3'd2,
    ST_MEM_WRITE = 3'd3,
    ST_DONE      = 3'd4
  } state_e;

  localparam logic [2:0] FETCH_BYTES = 3'd4;

  // The illegal encoding falls into the word case on purpose.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (mem_len_e'(len))
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the CPU pipeline (master) and mem_ctrl (slave).
// Fetch and data ports are held-request / single-cycle done pulse handshakes.
interface mem_ctrl_if #(parameter int ADDR_W = 32);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic [31:0]       if_inst_o;
  logic              if_done;

  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata_o;
  logic              mem_done;

  modport master (
    output if_req, if_addr, if_cancel, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  if_inst_o, if_done, mem_rdata_o, mem_done
  );

  modport slave (
    input  if_req, if_addr, if_cancel, mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output if_inst_o, if_done, mem_rdata_o, mem_done
  );

endinterface

// File: rtl/mem_ctrl_fetch_buf.sv
// One-entry {valid, addr, word} cache of the last completed instruction fetch.
// Lookup is combinational; fill and clear take effect on the next clock.
module fetch_buf #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [31:0]       fill_word_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [31:0]       word_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    word_d  = word_q;
    if (clr_i) begin
      valid_d = 1'b0;
    end else if (fill_i) begin
      valid_d = 1'b1;
      addr_d  = fill_addr_i;
      word_d  = fill_word_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  assign hit_o  = valid_q && (addr_q == lookup_addr_i);
  assign word_o = word_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetch and load/store (store/load wins).
// Reads take n+2 cycles, writes n+1; optional fetch buffer under FETCH_BUF_EN.
module mem_ctrl
  import cpu_defs::*;
#(
  parameter int ADDR_W  = 32,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  mem_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              mem_busy_o
);

  localparam logic [2:0] LAT = 3'(RAM_LAT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [31:0]       inst_q, inst_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [2:0]        n_q, n_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              is_if_q, is_if_d;

  logic              rd_last;
  logic [1:0]        byte_idx;
  logic              fb_hit;
  logic [31:0]       fb_word;

  // Read phase counts RAM_LAT extra cycles so the last byte can arrive.
  assign rd_last  = (cnt_q == n_q + LAT - 3'd1);
  assign byte_idx = 2'(cnt_q - LAT);

`ifdef FETCH_BUF_EN
  logic fb_fill;
  logic fb_clr;

  assign fb_fill = (state_q == ST_IF_READ) && !bus.if_cancel && rd_last;
  assign fb_clr  = (state_q == ST_IDLE) && bus.mem_req && bus.mem_we;

  fetch_buf #(.ADDR_W(ADDR_W)) u_fetch_buf (
    .clk           (clk),
    .rst           (rst),
    .fill_i        (fb_fill),
    .fill_addr_i   (base_q),
    .fill_word_i   (rbuf_d),
    .clr_i         (fb_clr),
    .lookup_addr_i (bus.if_addr),
    .hit_o         (fb_hit),
    .word_o        (fb_word)
  );
`else
  assign fb_hit  = 1'b0;
  assign fb_word = '0;
`endif

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    inst_d   = inst_q;
    rdata_d  = rdata_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    is_if_d  = is_if_q;
    ram_a    = '0;
    ram_wr   = 1'b0;
    ram_dout = 8'h00;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.mem_req) begin
          base_d  = bus.mem_addr;
          wdata_d = bus.mem_wdata;
          n_d     = len_bytes(bus.mem_len);
          cnt_d   = 3'd0;
          rbuf_d  = '0;
          is_if_d = 1'b0;
          state_d = bus.mem_we ? ST_MEM_WRITE : ST_MEM_READ;
        end else if (bus.if_req && !bus.if_cancel) begin
          base_d  = bus.if_addr;
          n_d     = FETCH_BYTES;
          cnt_d   = 3'd0;
          rbuf_d  = '0;
          is_if_d = 1'b1;
          if (fb_hit) begin
            inst_d  = fb_word;
            state_d = ST_DONE;
          end else begin
            state_d = ST_IF_READ;
          end
        end
      end

      ST_IF_READ, ST_MEM_READ: begin
        if (cnt_q < n_q) ram_a = base_q + ADDR_W'(cnt_q);
        if (cnt_q >= LAT) rbuf_d[{byte_idx, 3'b000} +: 8] = ram_din;
        if (state_q == ST_IF_READ && bus.if_cancel) begin
          state_d = ST_IDLE;
        end else if (rd_last) begin
          state_d = ST_DONE;
          if (is_if_q) inst_d = rbuf_d;
          else         rdata_d = rbuf_d;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end

      ST_MEM_WRITE: begin
        ram_wr   = 1'b1;
        ram_a    = base_q + ADDR_W'(cnt_q);
        ram_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (cnt_q == n_q - 3'd1) state_d = ST_DONE;
        else                     cnt_d   = cnt_q + 3'd1;
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      wdata_q <= '0;
      rbuf_q  <= '0;
      inst_q  <= '0;
      rdata_q <= '0;
      n_q     <= 3'd0;
      cnt_q   <= 3'd0;
      is_if_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rbuf_q  <= rbuf_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      is_if_q <= is_if_d;
    end
  end

  assign bus.if_inst_o   = inst_q;
  assign bus.mem_rdata_o = rdata_q;
  assign bus.if_done     = (state_q == ST_DONE) && is_if_q;
  assign bus.mem_done    = (state_q == ST_DONE) && !is_if_q;
  assign mem_busy_o      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32: width of all address ports.
REQ-002 Parameter RAM_LAT, default 1: cycles from ram_a to valid ram_din; only 1 is supported.
REQ-003 clk  in  1  system clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req  in  1  instruction fetch request, held until if_done or cancel.
REQ-006 if_addr  in  ADDR_W  fetch byte address.
REQ-007 if_cancel  in  1  branch flush, aborts the pending or active fetch.
REQ-008 if_inst_o  out  32  fetched word, little-endian.
REQ-009 if_done  out  1  one-cycle pulse, if_inst_o valid.
REQ-010 mem_req  in  1  data access request, held until mem_done.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_len  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
REQ-013 mem_addr  in  ADDR_W  data byte address.
REQ-014 mem_wdata  in  32  store data, low bytes first.
REQ-015 mem_rdata_o  out  32  load data, zero-extended.
REQ-016 mem_done  out  1  one-cycle completion pulse.
REQ-017 ram_a  out  ADDR_W  RAM byte address.
REQ-018 ram_dout  out  8  RAM write byte.
REQ-019 ram_wr  out  1  RAM write enable.
REQ-020 ram_din  in  8  RAM read byte.
REQ-021 mem_busy_o  out  1  high whenever state != IDLE; drives the pipeline stall controller.

Function
REQ-022 FSM states: IDLE, IF_READ, MEM_READ, MEM_WRITE, DONE.
REQ-023 Byte count n: 1, 2 or 4 per mem_len; fetches always use n = 4.
REQ-024 In IDLE, when mem_req and if_req are both high, mem_req wins; the fetch waits.
REQ-025 A request is accepted in IDLE at cycle T; the controller latches the address, data, n and we at T.
REQ-026 READ state lasts cycles T+1..T+n+1: it drives ram_a = base+k in cycle T+1+k and captures ram_din into byte k at the end of cycle T+2+k.
REQ-027 WRITE state lasts cycles T+1..T+n: it drives ram_wr=1, ram_a=base+k and ram_dout=wdata[8k+7:8k] in cycle T+1+k.
REQ-028 DONE lasts one cycle (read: T+n+2; write: T+n+1), pulses the matching done signal, then returns to IDLE.
REQ-029 A request still high in the DONE cycle is ignored; it is resampled in IDLE.
REQ-030 Read data stays stable on its output until the next completion of the same requester.
REQ-031 Address arithmetic wraps modulo 2^ADDR_W.
REQ-032 if_cancel during IF_READ moves the FSM to IDLE next cycle, with no if_done and no output update.
REQ-033 if_cancel in IDLE blocks acceptance of if_req in that cycle.
REQ-034 if_cancel has no effect on MEM_READ or MEM_WRITE.
REQ-035 mem_len = 3 is treated as a word access.
REQ-036 Outside WRITE: ram_wr = 0 and ram_dout = 0.

Reset
REQ-037 rst asserted at any time forces IDLE and aborts any transfer without a done pulse.
REQ-038 During reset all outputs are 0, including ram_wr, mem_busy_o and both data outputs.

Configuration
REQ-039 With FETCH_BUF_EN defined, a one-entry buffer holds {valid, addr, word} of the last completed fetch.
REQ-040 A buffer hit is an if_req accepted in IDLE with valid and addr == if_addr; the hit goes straight to DONE, so if_done occurs at T+1 with no RAM traffic.
REQ-041 Any accepted store clears the buffer's valid bit, and so does reset.
REQ-042 Without FETCH_BUF_EN there is no buffer and every fetch uses RAM.

Structure
REQ-043 The shared package cpu_defs holds the mem_len encoding and the FSM state encoding.
REQ-044 The buffer is the sub-module fetch_buf, instantiated only under FETCH_BUF_EN.

Verification
REQ-045 Fetch at 0x100 with RAM bytes 13,00,50,00 -> if_done at T+6 and if_inst_o = 0x00500013.
REQ-046 mem_req (store word 0xDEADBEEF at 0x20) and if_req in the same cycle -> writes EF,BE,AD,DE at 0x20..0x23 in T+1..T+4, mem_done at T+5, fetch accepted at T+6.
REQ-047 Load half at 0x3FE with RAM bytes 34,12 -> mem_rdata_o = 0x00001234 and mem_done at T+4.
REQ-048 if_cancel at T+2 of a fetch -> IDLE at T+3, no if_done, mem_busy_o low at T+3.
REQ-049 rst pulsed mid-store after 2 bytes -> ram_wr drops immediately, no mem_done, and IDLE after release.
REQ-050 FETCH_BUF_EN, repeating the fetch from 0x100 -> if_done at T+1 with no ram_a activity; after a store, the same fetch takes 6 cycles.
